// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the counter arbiter: FSM state encoding,
// default sizing and the helper that sizes requester index fields.
package counter_arb_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } arbState_e;

    // Width of an index that selects one of n requesters (never narrower than 1 bit).
    function automatic int sliceWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_arbiter_down_counter.sv
// Loadable down counter that saturates at zero; clear wins over load,
// load wins over decrement.
module down_counter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared down counter to N_REQ requesters,
// pulsing Done to the owner when its requested length has elapsed.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Start,
    input  logic [N_REQ*CNT_W-1:0]   Length,
    output logic [N_REQ-1:0]         Grant,
    output logic [N_REQ-1:0]         Done,
    output logic                     Busy,
    output logic [CNT_W-1:0]         Count
);

    localparam int IDX_W = sliceWidth(N_REQ);

    arbState_e          r_state;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   r_last;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;

    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic               w_selStart;
    logic               w_active;
    logic               w_load;
    logic               w_enable;
    logic               w_clear;
    logic               w_zero;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_lenArr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_lenSlice
        assign w_lenArr[g] = Length[g*CNT_W +: CNT_W];
    end

    // Search starts just after the most recent owner so every requester gets a turn.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
            if (!w_found && Start[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_selStart = Start[r_sel];
    assign w_active   = (r_state == LOAD) || (r_state == COUNT);
    assign w_clear    = w_active && !w_selStart;
    assign w_load     = (r_state == LOAD) && w_selStart;
    assign w_enable   = (r_state == COUNT) && w_selStart;

    down_counter #(
        .WIDTH(CNT_W)
    ) u_downCounter (
        .i_clock    (Clock),
        .i_reset    (Reset),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_loadValue(w_lenArr[r_sel]),
        .i_enable   (w_enable),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= IDX_W'(N_REQ - 1);
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= LOAD;
                        r_sel   <= w_pick;
                        r_last  <= w_pick;
                        r_grant <= N_REQ'(1) << w_pick;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD, COUNT: begin
                    // Owner withdrawing its request abandons the count silently.
                    if (!w_selStart) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_state == LOAD) begin
                        r_state <= COUNT;
                    end else if (w_zero) begin
                        r_state <= DONE;
                        r_done  <= r_grant;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant = r_grant;
    assign Done  = r_done;
    assign Busy  = r_busy;
    assign Count = w_count;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: a cycle-offset reference model queues
// expected outputs, and a monitor pops and compares them every cycle.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         busy;
        logic [W-1:0] count;
    } expect_t;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [N-1:0]   Start = '0;
    logic [N*W-1:0] Length = '0;
    logic [N-1:0]   Grant;
    logic [N-1:0]   Done;
    logic           Busy;
    logic [W-1:0]   Count;

    int testsRun    = 0;
    int testsFailed = 0;
    int monCycle    = 0;

    expect_t expQ[$];
    expect_t lastExp;
    int grantLog[$];
    int loadLog[$];
    int doneLog[$];
    int doneCycLog[$];

    // Reference model: owner, cycles elapsed since LOAD, sampled length.
    int mOwner = -1;
    int mK     = 0;
    int mLen   = 0;
    int mLast  = N - 1;
    int mCnt   = 0;

    counter_arbiter #(
        .N_REQ(N),
        .CNT_W(W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Length(Length),
        .Grant (Grant),
        .Done  (Done),
        .Busy  (Busy),
        .Count (Count)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, monCycle, actual, expected);
        end
    endtask

    function automatic logic [N*W-1:0] packLen(input int l0, input int l1, input int l2, input int l3);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    function automatic int logAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Outputs after an edge follow from the inputs sampled at that edge.
    function automatic void modelStep(input logic rst, input logic [N-1:0] st, input logic [N*W-1:0] lens);
        expect_t e;
        int c;
        if (rst) begin
            mOwner = -1;
            mCnt   = 0;
            mLast  = N - 1;
        end else if (mOwner < 0) begin
            for (int j = 1; j <= N; j++) begin
                c = (mLast + j) % N;
                if (st[c]) begin
                    mOwner = c;
                    mLast  = c;
                    mK     = 0;
                    break;
                end
            end
        end else if (mK <= mLen + 1 && !st[mOwner]) begin
            mOwner = -1;
            mCnt   = 0;
        end else if (mK > 0 && mK == mLen + 2) begin
            mOwner = -1;
        end else begin
            if (mK == 0) mLen = int'(lens[mOwner*W +: W]);
            mK++;
            mCnt = (mK <= mLen + 1) ? mLen - (mK - 1) : 0;
        end
        e.grant = '0;
        e.done  = '0;
        if (mOwner >= 0) begin
            e.grant[mOwner] = 1'b1;
            if (mK > 0 && mK == mLen + 2) e.done[mOwner] = 1'b1;
        end
        e.busy  = (mOwner >= 0);
        e.count = W'(mCnt);
        expQ.push_back(e);
        lastExp = e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [N-1:0] st, input logic [N*W-1:0] lens);
        @(negedge Clock);
        Reset  = rst;
        Start  = st;
        Length = lens;
        modelStep(rst, st, lens);
    endtask

    task automatic drain();
        @(posedge Clock);
        #2;
    endtask

    task automatic clearLogs();
        grantLog.delete();
        loadLog.delete();
        doneLog.delete();
        doneCycLog.delete();
    endtask

    initial begin
        expect_t e;
        logic [N-1:0] prevGrant;
        prevGrant = '0;
        forever begin
            @(posedge Clock);
            #1;
            monCycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("grant", 32'(Grant), 32'(e.grant));
                checkOutput("done",  32'(Done),  32'(e.done));
                checkOutput("busy",  32'(Busy),  32'(e.busy));
                checkOutput("count", 32'(Count), 32'(e.count));
            end
            if (Grant != '0 && prevGrant == '0) begin
                grantLog.push_back(int'(Grant));
                loadLog.push_back(monCycle);
            end
            if (Done != '0) begin
                doneLog.push_back(int'(Done));
                doneCycLog.push_back(monCycle);
            end
            prevGrant = Grant;
        end
    end

    initial begin
        logic [N*W-1:0] lens;
        logic [N-1:0]   agentOn;
        int             expOrder[5];
        logic           rst;

        // Single owner, length 3.
        applyStimulus(1'b1, '0, '0);
        drain();
        clearLogs();
        lens = packLen(3, 0, 0, 0);
        repeat (7) applyStimulus(1'b0, 4'b0001, lens);
        repeat (3) applyStimulus(1'b0, 4'b0000, lens);
        drain();
        checkOutput("s1 grant events", grantLog.size(), 1);
        checkOutput("s1 grant value", logAt(grantLog, 0), 1);
        checkOutput("s1 done value", logAt(doneLog, 0), 1);
        checkOutput("s1 load to done", logAt(doneCycLog, 0) - logAt(loadLog, 0), 5);

        // All requesters with zero length rotate from requester 0.
        applyStimulus(1'b1, '0, '0);
        drain();
        clearLogs();
        lens = packLen(0, 0, 0, 0);
        repeat (20) applyStimulus(1'b0, 4'b1111, lens);
        repeat (4) applyStimulus(1'b0, 4'b0000, lens);
        drain();
        expOrder = '{1, 2, 4, 8, 1};
        checkOutput("s2 grant events", grantLog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("s2 grant order", logAt(grantLog, i), expOrder[i]);
            checkOutput("s2 load to done", logAt(doneCycLog, i) - logAt(loadLog, i), 2);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("s2 done to next load", logAt(loadLog, i + 1) - logAt(doneCycLog, i), 2);
        end

        // Requester 2 withdraws during its fourth COUNT cycle.
        clearLogs();
        lens = packLen(0, 0, 10, 0);
        repeat (5) applyStimulus(1'b0, 4'b0100, lens);
        repeat (4) applyStimulus(1'b0, 4'b0000, lens);
        drain();
        checkOutput("s3 grant value", logAt(grantLog, 0), 4);
        checkOutput("s3 done events", doneLog.size(), 0);

        // Length changed after LOAD must not affect the running count.
        clearLogs();
        repeat (2) applyStimulus(1'b0, 4'b0010, packLen(0, 5, 0, 0));
        repeat (7) applyStimulus(1'b0, 4'b0010, packLen(0, 9, 0, 0));
        repeat (3) applyStimulus(1'b0, 4'b0000, packLen(0, 9, 0, 0));
        drain();
        checkOutput("s4 done value", logAt(doneLog, 0), 2);
        checkOutput("s4 load to done", logAt(doneCycLog, 0) - logAt(loadLog, 0), 7);

        // Reset mid-count, then requesters 0 and 3 together.
        clearLogs();
        lens = packLen(2, 0, 20, 1);
        repeat (5) applyStimulus(1'b0, 4'b0100, lens);
        applyStimulus(1'b1, 4'b0100, lens);
        repeat (10) applyStimulus(1'b0, 4'b1001, lens);
        repeat (4) applyStimulus(1'b0, 4'b0000, lens);
        drain();
        checkOutput("s5 first grant", logAt(grantLog, 0), 4);
        checkOutput("s5 grant after reset", logAt(grantLog, 1), 1);
        checkOutput("s5 second grant after reset", logAt(grantLog, 2), 8);
        checkOutput("s5 done events", doneLog.size(), 2);
        checkOutput("s5 first done", logAt(doneLog, 0), 1);

        // Random requesters: hold until Done, occasionally withdraw or reset.
        applyStimulus(1'b1, '0, '0);
        agentOn = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if (agentOn[i]) begin
                    if (lastExp.done[i] || $urandom_range(0, 39) == 0) agentOn[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    agentOn[i] = 1'b1;
                end
                lens[i*W +: W] = W'($urandom_range(0, 9));
            end
            applyStimulus(rst, agentOn, lens);
        end
        repeat (3) applyStimulus(1'b0, '0, lens);
        drain();
        checkOutput("scoreboard empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters sharing the counter.
REQ-002 The block SHALL have parameter CNT_W, default 8: counter width in bits.
REQ-003 The block SHALL have port Clock  input  1: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-005 The block SHALL have port Start  input  N_REQ: per-requester level request, held until that requester's Done.
REQ-006 The block SHALL have port Length  input  N_REQ*CNT_W: per-requester count length; slice i is bits [i*CNT_W +: CNT_W].
REQ-007 The block SHALL have port Grant  output  N_REQ: one-hot owner of the counter; all zero when idle.
REQ-008 The block SHALL have port Done  output  N_REQ: one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port Busy  output  1: high while the counter is owned.
REQ-010 The block SHALL have port Count  output  CNT_W: current counter value.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, COUNT and DONE.
REQ-012 In IDLE with any Start bit high, the block SHALL select one requester round-robin and go to LOAD next cycle; with no Start bit high it SHALL stay in IDLE.
REQ-013 Round-robin selection SHALL search from index last+1 upward with wrap, where last is the most recently granted index.
REQ-014 The last pointer SHALL update to the selected index when LOAD is entered.
REQ-015 In LOAD, the block SHALL register Count from the selected Length slice and go to COUNT; Length SHALL be sampled only in this cycle.
REQ-016 In COUNT with Count==0, the block SHALL go to DONE; otherwise Count SHALL decrement by 1 and the FSM SHALL stay in COUNT.
REQ-017 DONE SHALL last exactly one cycle: Done[sel]=1 and all other Done bits 0, then the FSM SHALL return to IDLE.
REQ-018 DONE SHALL therefore be reached exactly L+2 cycles after LOAD for length L; L=0 is legal and SHALL give DONE 2 cycles after LOAD.
REQ-019 Grant[sel] SHALL be high in LOAD, COUNT and DONE and SHALL be zero in IDLE.
REQ-020 Busy SHALL be high exactly in LOAD, COUNT and DONE.
REQ-021 Abort: if Start[sel] falls in LOAD or COUNT, the FSM SHALL go to IDLE next cycle with no Done pulse and SHALL clear Count to 0.
REQ-022 Start of non-owners SHALL be ignored until IDLE; Start changes during DONE SHALL be ignored.
REQ-023 The minimum gap between grants SHALL be one IDLE cycle after DONE.
REQ-024 A requester still holding Start in IDLE SHALL be treated as a new request and is subject to round-robin.
REQ-025 Count SHALL hold 0 in DONE and keep its last value in IDLE.
REQ-026 The counter SHALL never wrap below 0.

Reset
REQ-027 Reset SHALL be synchronous and active-high, and SHALL take priority over all other behaviour.
REQ-028 On reset the block SHALL set state=IDLE, Grant=0, Done=0, Busy=0, Count=0 and last=N_REQ-1, so requester 0 wins first.
REQ-029 Reset mid-operation SHALL abandon the owner with no Done pulse; normal operation SHALL resume on the first cycle after Reset falls.

Structure
REQ-030 Package counter_arb_pkg SHALL hold the state enum, the default N_REQ/CNT_W constants and the slice-width helper.
REQ-031 The block SHALL instantiate one sub-module, down_counter, with load/enable/clear inputs and a zero flag.
REQ-032 Arbitration and the FSM SHALL stay in counter_arbiter.

Verification
REQ-033 The bench SHALL check: Reset 1 cycle, then Start=0001, Length[0]=3 -> LOAD next cycle, Count 3,2,1,0, Done=0001 exactly 5 cycles after LOAD, Grant=0001 throughout, Busy falls after DONE.
REQ-034 The bench SHALL check: Start=1111 held, Lengths=0 -> grants in order 0001,0010,0100,1000,0001, each with Done 2 cycles after LOAD and one IDLE cycle between grants.
REQ-035 The bench SHALL check: Start[2] with Length=10, drop Start[2] at the 4th COUNT cycle -> IDLE next cycle, no Done, Count=0, Grant=0.
REQ-036 The bench SHALL check: Length[1] changed from 5 to 9 during COUNT -> count still ends after 5, Done=0010 at LOAD+7.
REQ-037 The bench SHALL check: Reset asserted mid-COUNT -> next cycle all outputs 0, no Done; after Reset falls, Start=1000 and 0001 together -> Grant=0001 first.
